// File: rtl/dec_7seg_if.sv
// rtl/dec_7seg_if.sv - nibble-in / segments-out bundle for one display digit
interface dec_7seg_if;
  logic [3:0] X;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       e;
  logic       f;
  logic       g;

  modport master (
    output X,
    input  a, b, c, d, e, f, g
  );

  modport slave (
    input  X,
    output a, b, c, d, e, f, g
  );
endinterface

// File: rtl/dec_7seg.sv
// rtl/dec_7seg.sv - registered hex-to-seven-segment decoder, one clock latency
module dec_7seg #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  dec_7seg_if.slave  seg_if
);

  // Polarity mask: applied to both decoded patterns and the blank reset value
  localparam logic [6:0] POL_MASK = {7{ACTIVE_LOW}};

  logic [6:0] lit;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // Bit order is {a,b,c,d,e,f,g}, a in the MSB
  always_comb begin
    lit = 7'b0000000;
    case (seg_if.X)
      4'h0:    lit = 7'b1111110;
      4'h1:    lit = 7'b0110000;
      4'h2:    lit = 7'b1101101;
      4'h3:    lit = 7'b1111001;
      4'h4:    lit = 7'b0110011;
      4'h5:    lit = 7'b1011011;
      4'h6:    lit = 7'b1011111;
      4'h7:    lit = 7'b1110000;
      4'h8:    lit = 7'b1111111;
      4'h9:    lit = 7'b1111011;
      4'hA:    lit = 7'b1110111;
      4'hB:    lit = 7'b0011111;
      4'hC:    lit = 7'b1001110;
      4'hD:    lit = 7'b0111101;
      4'hE:    lit = 7'b1001111;
      4'hF:    lit = 7'b1000111;
      default: lit = 7'b0000000;
    endcase
    seg_d = lit ^ POL_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= POL_MASK;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_if.a = seg_q[6];
  assign seg_if.b = seg_q[5];
  assign seg_if.c = seg_q[4];
  assign seg_if.d = seg_q[3];
  assign seg_if.e = seg_q[2];
  assign seg_if.f = seg_q[1];
  assign seg_if.g = seg_q[0];

endmodule

// File: tb/tb_dec_7seg.sv
// tb/tb_dec_7seg.sv - directed self-checking bench for both output polarities
module tb_dec_7seg;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dec_7seg_if if_hi();
  dec_7seg_if if_lo();

  dec_7seg #(.ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk    (clk),
    .rst    (rst),
    .seg_if (if_hi.slave)
  );

  dec_7seg #(.ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk    (clk),
    .rst    (rst),
    .seg_if (if_lo.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] exp_map [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] segs_hi();
    return {if_hi.a, if_hi.b, if_hi.c, if_hi.d, if_hi.e, if_hi.f, if_hi.g};
  endfunction

  function automatic logic [6:0] segs_lo();
    return {if_lo.a, if_lo.b, if_lo.c, if_lo.d, if_lo.e, if_lo.f, if_lo.g};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    if_hi.X = 4'h8;
    if_lo.X = 4'h8;

    tick();
    check("reset_hi_edge1", segs_hi(), 7'b0000000);
    check("reset_lo_edge1", segs_lo(), 7'b1111111);
    tick();
    check("reset_hi_edge2", segs_hi(), 7'b0000000);
    check("reset_lo_edge2", segs_lo(), 7'b1111111);

    rst = 1'b0;
    tick();
    check("release_hi_8", segs_hi(), 7'b1111111);
    check("release_lo_8", segs_lo(), 7'b0000000);

    if_lo.X = 4'h1;
    tick();
    check("lo_1", segs_lo(), 7'b1001111);

    for (int i = 0; i < 16; i++) begin
      if_hi.X = 4'(i);
      if_lo.X = 4'(i);
      tick();
      check($sformatf("sweep_hi_%0h", i), segs_hi(), exp_map[i]);
      check($sformatf("sweep_lo_%0h", i), segs_lo(), ~exp_map[i]);
    end

    if_hi.X = 4'hF;
    tick();
    check("wrap_f", segs_hi(), 7'b1000111);
    if_hi.X = 4'h0;
    tick();
    check("wrap_0", segs_hi(), 7'b1111110);
    if_hi.X = 4'h1;
    tick();
    check("wrap_1", segs_hi(), 7'b0110000);

    if_hi.X = 4'h2;
    tick();
    check("lat_2", segs_hi(), 7'b1101101);
    if_hi.X = 4'h7;
    #3;
    check("lat_hold", segs_hi(), 7'b1101101);
    tick();
    check("lat_7", segs_hi(), 7'b1110000);

    if_hi.X = 4'h3;
    tick();
    check("prio_pre", segs_hi(), 7'b1111001);
    rst = 1'b1;
    tick();
    check("prio_rst", segs_hi(), 7'b0000000);
    rst = 1'b0;
    tick();
    check("prio_post", segs_hi(), 7'b1111001);
    tick();
    check("hold_stable", segs_hi(), 7'b1111001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_7seg.md
# dec_7seg

Registered hexadecimal-to-seven-segment decoder. Converts a 4-bit nibble X (0x0–0xF) into the seven individual segment drives a–g of one common display digit. It sits between the value-producing logic (counters, display multiplexer) and the board-level segment pins. Outputs are registered on the single system clock and cleared by synchronous reset.

## Interface
- ACTIVE_LOW, default 0: 0 means segment output 1 = lit; 1 means every segment output is inverted (0 = lit, blank = all 1).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- X  input  4  unsigned nibble to display, 0x0–0xF.
- a  output  1  top segment.
- b  output  1  upper-right segment.
- c  output  1  lower-right segment.
- d  output  1  bottom segment.
- e  output  1  lower-left segment.
- f  output  1  upper-left segment.
- g  output  1  middle segment.

## Operation
- Segment map for logical "lit" (before ACTIVE_LOW inversion); listed segments lit, all others dark:
  - 0: a b c d e f | 1: b c | 2: a b d e g | 3: a b c d g
  - 4: b c f g | 5: a c d f g | 6: a c d e f g | 7: a b c
  - 8: a b c d e f g | 9: a b c d f g | A: a b c e f g | b: c d e f g
  - C: a d e f | d: b c d e g | E: a d e f g | F: a e f g
- All 16 codes are valid and decoded; there is no invalid input and no default/blank code other than reset.
- Decode is purely a function of the sampled X; no history, no counters, no state machine beyond the seven output registers.
- ACTIVE_LOW applies as a final XOR on all seven bits, including the reset (blank) value.
- X is sampled only at the clock edge; glitches between edges never reach the outputs.
- X containing X/Z bits: outputs are don't-care for that cycle; no requirement beyond recovering on the next clean sample.

## Timing
- Latency: 1 clock. Pattern for X present at rising edge N appears on a–g immediately after edge N and holds until edge N+1.
- Outputs change only on a rising clk edge; no combinational path from X to a–g.
- Reset: if rst=1 at a rising edge, all seven outputs go to blank (all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1) after that edge, regardless of X.
- Reset value before the first clock edge with rst asserted is undefined; the system holds rst for at least one edge at power-up.
- rst has priority over decode. Deasserting rst at edge N: the output after edge N is the decode of X sampled at edge N.
- Reset mid-operation: the displayed digit is lost immediately (one edge); no pending update survives.
- X wrap-around 0xF -> 0x0: decoded normally, no special handling.
- X held constant: outputs remain stable, no toggling.

## Test plan
- Reset: rst=1 for 2 cycles with X=0x8 -> a..g = 0000000 after first edge; release rst -> 1111111 one edge later.
- Full sweep: X counts 0x0..0xF, one value per clock, rst=0 -> each abcdefg matches the map one cycle later (e.g. 0x0 -> 1111110, 0x1 -> 0110000, 0xA -> 1110111, 0xF -> 1000111).
- Wrap: X steps 0xF -> 0x0 -> 0x1 -> outputs 1000111, 1111110, 0110000 on consecutive cycles.
- Latency/no combinational path: change X from 0x2 to 0x7 mid-cycle -> outputs remain 1101101 until next rising edge, then 1110000.
- Reset priority: X=0x3 stable, assert rst for one edge mid-stream -> outputs 0000000 for exactly one cycle, then 1111001.
- ACTIVE_LOW=1 instance: reset -> 1111111; X=0x8 -> 0000000; X=0x1 -> 1001111.
